// File: rtl/acs_scheduler_if.sv
// Symbol-input and survivor-output handshakes of the ACS scheduler.
// The slave modport is the scheduler side; master is the producer/consumer side.
interface acs_scheduler_if;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym_data;
    logic       sym_start;
    logic       surv_valid;
    logic       surv_ready;
    logic [7:0] surv_bits;
    logic [7:0] surv_mask;
    logic [2:0] best_state;
    logic [7:0] best_metric;

    modport master (
        output sym_valid, sym_data, sym_start, surv_ready,
        input  sym_ready, surv_valid, surv_bits, surv_mask, best_state, best_metric
    );

    modport slave (
        input  sym_valid, sym_data, sym_start, surv_ready,
        output sym_ready, surv_valid, surv_bits, surv_mask, best_state, best_metric
    );
endinterface

// File: rtl/acs_scheduler.sv
// Time-shares one external combinational ACS over the 8 states of a K=4 rate-1/2 trellis,
// keeping path metrics in ping-pong banks and emitting one survivor record per symbol.
module acs_scheduler #(
    parameter logic [3:0]  G0       = 4'b1101,
    parameter logic [3:0]  G1       = 4'b1111,
    parameter int unsigned NORM_BIT = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    acs_scheduler_if.slave        bus,
    output logic                  acs_path_0_valid,
    output logic                  acs_path_1_valid,
    output logic [1:0]            acs_path_0_bmc,
    output logic [1:0]            acs_path_1_bmc,
    output logic [7:0]            acs_path_0_pmc,
    output logic [7:0]            acs_path_1_pmc,
    input  logic                  acs_selection,
    input  logic                  acs_valid_o,
    input  logic [7:0]            acs_path_cost
);

    typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q;
    logic       bank_q;
    logic [7:0] pm_q [2][8];
    logic [7:0] pv_q [2];
    logic [1:0] sym_q;
    logic [7:0] surv_bits_q;
    logic [7:0] surv_mask_q;
    logic [2:0] best_state_q;
    logic [7:0] best_metric_q;
    logic       best_found_q;

    logic       nb;
    logic [2:0] p0, p1;
    logic [1:0] bmc0, bmc1;
    logic       sym_hs, surv_hs;
    logic       norm_all;

    // Hamming distance between the codeword expected for transition w={u,pred} and rx.
    function automatic logic [1:0] bmc_of(input logic [3:0] w, input logic [1:0] rx);
        logic [1:0] diff;
        diff = {^(G0 & w), ^(G1 & w)} ^ rx;
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    assign nb      = ~bank_q;
    assign p0      = {idx_q[1:0], 1'b0};
    assign p1      = {idx_q[1:0], 1'b1};
    assign bmc0    = bmc_of({idx_q[2], p0}, sym_q);
    assign bmc1    = bmc_of({idx_q[2], p1}, sym_q);
    assign sym_hs  = bus.sym_valid && bus.sym_ready;
    assign surv_hs = bus.surv_valid && bus.surv_ready;

    assign bus.sym_ready   = (state_q == StIdle);
    assign bus.surv_valid  = (state_q == StOut);
    assign bus.surv_bits   = surv_bits_q;
    assign bus.surv_mask   = surv_mask_q;
    assign bus.best_state  = best_state_q;
    assign bus.best_metric = best_metric_q;

    // Normalise only when every surviving metric has crossed the threshold bit.
    always_comb begin
        norm_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (pv_q[nb][i] && !pm_q[nb][i][NORM_BIT]) norm_all = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (sym_hs) state_d = StRun;
            StRun:   if (idx_q == 3'd7) state_d = StOut;
            StOut:   if (surv_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        acs_path_0_valid = 1'b0;
        acs_path_1_valid = 1'b0;
        acs_path_0_bmc   = 2'd0;
        acs_path_1_bmc   = 2'd0;
        acs_path_0_pmc   = 8'd0;
        acs_path_1_pmc   = 8'd0;
        if (state_q == StRun) begin
            acs_path_0_valid = pv_q[bank_q][p0];
            acs_path_1_valid = pv_q[bank_q][p1];
            acs_path_0_bmc   = bmc0;
            acs_path_1_bmc   = bmc1;
            acs_path_0_pmc   = pm_q[bank_q][p0];
            acs_path_1_pmc   = pm_q[bank_q][p1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= 3'd0;
            bank_q        <= 1'b0;
            sym_q         <= 2'd0;
            surv_bits_q   <= 8'd0;
            surv_mask_q   <= 8'd0;
            best_state_q  <= 3'd0;
            best_metric_q <= 8'd0;
            best_found_q  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                pv_q[b] <= 8'h01;
                for (int i = 0; i < 8; i++) pm_q[b][i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (sym_hs) begin
                        sym_q         <= bus.sym_data;
                        idx_q         <= 3'd0;
                        surv_bits_q   <= 8'd0;
                        surv_mask_q   <= 8'd0;
                        best_state_q  <= 3'd0;
                        best_metric_q <= 8'd0;
                        best_found_q  <= 1'b0;
                        if (bus.sym_start) begin
                            pv_q[bank_q] <= 8'h01;
                            for (int i = 0; i < 8; i++) pm_q[bank_q][i] <= 8'd0;
                        end
                    end
                end
                StRun: begin
                    idx_q              <= idx_q + 3'd1;
                    pm_q[nb][idx_q]    <= acs_valid_o ? acs_path_cost : 8'd0;
                    pv_q[nb][idx_q]    <= acs_valid_o;
                    surv_bits_q[idx_q] <= acs_valid_o & acs_selection;
                    surv_mask_q[idx_q] <= acs_valid_o;
                    // Strict compare keeps the lower index on ties.
                    if (acs_valid_o && (!best_found_q || acs_path_cost < best_metric_q)) begin
                        best_found_q  <= 1'b1;
                        best_state_q  <= idx_q;
                        best_metric_q <= acs_path_cost;
                    end
                end
                StOut: begin
                    if (surv_hs) begin
                        bank_q <= nb;
                        if (norm_all) begin
                            for (int i = 0; i < 8; i++) begin
                                if (pv_q[nb][i]) pm_q[nb][i][NORM_BIT] <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acs_scheduler.sv
// Scoreboard bench for acs_scheduler: a behavioural ACS drives the DUT's ACS inputs and a
// forward-trellis reference model queues the expected survivor record for each symbol.
module tb_acs_scheduler;

    localparam logic [3:0] G0 = 4'b1101;
    localparam logic [3:0] G1 = 4'b1111;

    typedef struct packed {
        logic [7:0] bits;
        logic [7:0] mask;
        logic [2:0] bs;
        logic [7:0] bm;
        logic       norm;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acs_scheduler_if bus ();

    logic       a0_valid, a1_valid, acs_sel, acs_vld;
    logic [1:0] a0_bmc, a1_bmc;
    logic [7:0] a0_pmc, a1_pmc, acs_cost, c0, c1;

    acs_scheduler #(.G0(G0), .G1(G1), .NORM_BIT(7)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .acs_path_0_valid (a0_valid),
        .acs_path_1_valid (a1_valid),
        .acs_path_0_bmc   (a0_bmc),
        .acs_path_1_bmc   (a1_bmc),
        .acs_path_0_pmc   (a0_pmc),
        .acs_path_1_pmc   (a1_pmc),
        .acs_selection    (acs_sel),
        .acs_valid_o      (acs_vld),
        .acs_path_cost    (acs_cost)
    );

    // Behavioural add-compare-select; ties pick path 0.
    always_comb begin
        c0 = a0_pmc + 8'(a0_bmc);
        c1 = a1_pmc + 8'(a1_bmc);
        acs_sel  = 1'b0;
        acs_vld  = 1'b0;
        acs_cost = 8'd0;
        if (a0_valid && a1_valid) begin
            acs_vld  = 1'b1;
            acs_sel  = (c1 < c0);
            acs_cost = (c1 < c0) ? c1 : c0;
        end else if (a0_valid) begin
            acs_vld  = 1'b1;
            acs_cost = c0;
        end else if (a1_valid) begin
            acs_vld  = 1'b1;
            acs_sel  = 1'b1;
            acs_cost = c1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] m_pm [8];
    logic [7:0] m_pv;
    rec_t       sb [$];

    function automatic logic [1:0] cw_of(input logic [3:0] w);
        return {^(G0 & w), ^(G1 & w)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_pm[i] = 8'd0;
        m_pv = 8'h01;
    endtask

    // Forward trellis step: each valid predecessor extends along both inputs.
    task automatic model_step(input logic [1:0] d, input logic st, output rec_t r);
        logic [7:0] nm [8];
        logic [7:0] nv;
        logic [7:0] c;
        logic [1:0] diff;
        logic [2:0] pp, ns;
        logic       found, all_hi;
        if (st) model_reset();
        r  = '0;
        nv = 8'd0;
        for (int i = 0; i < 8; i++) nm[i] = 8'd0;
        for (int p = 0; p < 8; p++) begin
            pp = 3'(p);
            if (m_pv[pp]) begin
                for (int u = 0; u < 2; u++) begin
                    ns   = {u[0], pp[2:1]};
                    diff = cw_of({u[0], pp}) ^ d;
                    c    = m_pm[pp] + 8'(diff[1]) + 8'(diff[0]);
                    if (!nv[ns] || c < nm[ns]) begin
                        nm[ns]     = c;
                        nv[ns]     = 1'b1;
                        r.bits[ns] = pp[0];
                    end
                end
            end
        end
        r.mask = nv;
        found  = 1'b0;
        all_hi = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (nv[n] && (!found || nm[n] < r.bm)) begin
                found = 1'b1;
                r.bs  = 3'(n);
                r.bm  = nm[n];
            end
            if (nv[n] && !nm[n][7]) all_hi = 1'b0;
        end
        r.norm = all_hi && (nv != 8'd0);
        if (all_hi) for (int n = 0; n < 8; n++) nm[n][7] = 1'b0;
        for (int n = 0; n < 8; n++) m_pm[n] = nm[n];
        m_pv = nv;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.surv_valid && bus.surv_ready) begin
            if (sb.size() == 0) begin
                check_val("sb_empty", 32'(sb.size()), 1);
            end else begin
                rec_t e;
                e = sb.pop_front();
                check_val("surv_bits", bus.surv_bits, e.bits);
                check_val("surv_mask", bus.surv_mask, e.mask);
                check_val("best_state", bus.best_state, e.bs);
                check_val("best_metric", bus.best_metric, e.bm);
            end
        end
    end

    task automatic send_sym(input logic [1:0] d, input logic st, input int hold,
                            output rec_t got, output rec_t exp);
        int   n;
        int   lat;
        rec_t e;
        got = '0;
        model_step(d, st, e);
        exp = e;
        n = 0;
        while (!bus.sym_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("accept_ready", bus.sym_ready, 1);
        if (!bus.sym_ready) return;
        sb.push_back(e);
        bus.sym_valid = 1'b1;
        bus.sym_data  = d;
        bus.sym_start = st;
        if (hold > 0) bus.surv_ready = 1'b0;
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        bus.sym_start = 1'b0;
        lat = 1;
        while (!bus.surv_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", lat, 9);
        if (!bus.surv_valid) begin
            sb.delete();
            bus.surv_ready = 1'b1;
            return;
        end
        got.bits = bus.surv_bits;
        got.mask = bus.surv_mask;
        got.bs   = bus.best_state;
        got.bm   = bus.best_metric;
        if (hold > 0) begin
            bus.sym_valid = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                check_val("hold_valid", bus.surv_valid, 1);
                check_val("hold_ready", bus.sym_ready, 0);
                check_val("hold_bits", bus.surv_bits, got.bits);
                check_val("hold_metric", {bus.best_state, bus.best_metric}, {got.bs, got.bm});
            end
            bus.sym_valid  = 1'b0;
            bus.surv_ready = 1'b1;
            @(posedge clk); #1;
            check_val("idle_after_hold", bus.sym_ready, 1);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rec_t got, exp;
        logic [2:0] enc_s;
        logic [1:0] cw;
        logic       u;
        logic [7:0] prev_bm;
        bit         norm_seen, dut_drop;
        int         extra;

        bus.sym_valid  = 1'b0;
        bus.sym_data   = 2'd0;
        bus.sym_start  = 1'b0;
        bus.surv_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_val("rst_sym_ready", bus.sym_ready, 1);
        check_val("rst_surv_valid", bus.surv_valid, 0);
        check_val("rst_outputs", {bus.surv_bits, bus.surv_mask, bus.best_state, bus.best_metric}, 0);
        check_val("rst_acs_idle", {a0_valid, a1_valid, a0_pmc, a1_pmc, a0_bmc, a1_bmc}, 0);

        // First symbol after reset with no start flag.
        send_sym(2'b00, 1'b0, 0, got, exp);
        check_val("first_mask", got.mask, 8'h11);
        check_val("first_bits", got.bits, 8'h00);
        check_val("first_best", {got.bs, got.bm}, 0);

        // Back-pressure on the survivor output with a pending symbol.
        send_sym(2'b01, 1'b0, 5, got, exp);

        // Reset while RUN is at idx 4.
        bus.sym_valid = 1'b1;
        bus.sym_data  = 2'b10;
        @(posedge clk); #1;
        bus.sym_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrst_sym_ready", bus.sym_ready, 1);
        check_val("midrst_surv_valid", bus.surv_valid, 0);
        check_val("midrst_outputs",
                  {bus.surv_bits, bus.surv_mask, bus.best_state, bus.best_metric}, 0);
        check_val("midrst_acs_idle", {a0_valid, a1_valid}, 0);
        model_reset();
        send_sym(2'b00, 1'b0, 0, got, exp);
        check_val("midrst_mask", got.mask, 8'h11);

        // All-zero message.
        for (int i = 0; i < 16; i++) begin
            send_sym(2'b00, (i == 0), 0, got, exp);
            check_val("zero_best", {got.bs, got.bm}, 0);
            if (i >= 2) check_val("zero_mask", got.mask, 8'hFF);
        end

        // Random message with one injected bit error.
        enc_s = 3'd0;
        for (int i = 0; i < 24; i++) begin
            u     = 1'($urandom_range(0, 1));
            cw    = cw_of({u, enc_s});
            enc_s = {u, enc_s[2:1]};
            if (i == 7) cw = cw ^ 2'b01;
            send_sym(cw, (i == 0), 0, got, exp);
        end

        // Noisy stream until metrics cross the normalisation threshold.
        norm_seen = 1'b0;
        dut_drop  = 1'b0;
        extra     = 0;
        prev_bm   = 8'd0;
        for (int i = 0; i < 1500 && extra < 4; i++) begin
            send_sym(2'($urandom_range(0, 3)), (i == 0), 0, got, exp);
            if (exp.norm) begin
                check_val("norm_pre_hi", got.bm[7], 1);
                norm_seen = 1'b1;
            end
            if (prev_bm >= 8'd128 && got.bm < 8'd128) dut_drop = 1'b1;
            prev_bm = got.bm;
            if (norm_seen) extra++;
        end
        check_val("norm_drop_seen", dut_drop, 1);

        // Mid-stream restart.
        send_sym(2'b11, 1'b1, 0, got, exp);
        check_val("restart_mask", got.mask, 8'h11);
        check_val("restart_best", {got.bs, got.bm}, {3'd4, 8'd0});

        repeat (3) @(posedge clk);
        #1 check_val("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/acs_scheduler.md
Name: acs_scheduler

Overview:
- Sequencer that time-shares one combinational ACS unit across all 8 trellis states of a K=4, rate-1/2 Viterbi decoder.
- Per received 2-bit symbol it:
  - computes branch metrics internally;
  - drives the ACS once per state;
  - stores new path metrics in ping-pong banks;
  - emits an 8-bit survivor vector, the valid mask and the best state to the trace-back stage.
- Sits between the symbol input and the trace-back memory.

Parameters:
- G0, 4'b1101, generator polynomial for codeword bit 1; MSB taps the newest input bit.
- G1, 4'b1111, generator polynomial for codeword bit 0.
- NORM_BIT, 7, metric bit that triggers normalization.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sym_valid  in  1  received symbol valid
- sym_ready  out  1  scheduler can accept a symbol
- sym_data  in  2  received codeword {G0 bit, G1 bit}
- sym_start  in  1  qualified by the sym handshake; reinitialise metrics before this symbol
- acs_path_0_valid  out  1  to ACS
- acs_path_1_valid  out  1  to ACS
- acs_path_0_bmc  out  2  to ACS
- acs_path_1_bmc  out  2  to ACS
- acs_path_0_pmc  out  8  to ACS
- acs_path_1_pmc  out  8  to ACS
- acs_selection  in  1  from ACS
- acs_valid_o  in  1  from ACS
- acs_path_cost  in  8  from ACS
- surv_valid  out  1  survivor record available
- surv_ready  in  1  trace-back accepts record
- surv_bits  out  8  bit n = ACS selection for state n
- surv_mask  out  8  bit n = state n valid
- best_state  out  3  lowest-metric valid state
- best_metric  out  8  its metric

Behaviour:
- Trellis conventions:
  - State s[2:0] holds the last 3 input bits, newest in the MSB.
  - Next state: ns = {u, s[2:1]}.
  - For state n, predecessors are p0 = {n[1:0],0} and p1 = {n[1:0],1}; input u = n[2].
  - Expected codeword for pX: {^(G0 & {u,pX}), ^(G1 & {u,pX})}.
  - bmc = Hamming distance between the expected codeword and sym_data (0..2).
- Storage:
  - Two banks of 8 × 8-bit metrics plus 8 valid bits; one bank is current, the other next.
  - Initial metrics: state 0 valid with metric 0; all other states invalid with metric 0.
- FSM states: IDLE, RUN, OUT.
- IDLE:
  - sym_ready=1.
  - On sym_valid && sym_ready: latch sym_data.
  - If sym_start, load initial metrics into the current bank.
  - Clear idx to 0 and go to RUN.
- RUN (8 cycles, idx 0..7, one state per cycle):
  - Drive the ACS with current-bank valid/metric of p0 and p1 for idx, plus both bmcs.
  - Same cycle: write acs_path_cost and acs_valid_o into next[idx]; write acs_selection into surv_bits[idx].
  - When acs_valid_o=0: store metric 0, valid 0, survivor bit 0.
  - Track the running minimum over valid states; ties keep the lower index.
  - After idx=7, go to OUT.
  - In IDLE/OUT, all acs_* outputs are 0.
- OUT:
  - surv_valid=1; surv_bits, surv_mask, best_state and best_metric are held stable until surv_ready.
  - On handshake: swap banks, then go to IDLE.
  - Normalization: if every valid metric in the new bank has bit NORM_BIT set, clear that bit in all of them during the swap.
  - best_metric reports the pre-normalization value.
- If no state is valid after RUN: best_state=0, best_metric=0.
- Latency: handshake in cycle 0; RUN in cycles 1..8; surv_valid asserts in cycle 9. Throughput is at most one symbol per 10 cycles.
- sym_ready is 0 outside IDLE. No symbol is buffered while busy.
- Reset (any state, mid-RUN or mid-OUT):
  - FSM returns to IDLE; idx=0; bank select=0.
  - Metrics are set to the initial values.
  - surv_valid=0; surv_bits, surv_mask, best_state, best_metric = 0; sym_ready=1 from the first cycle after reset.
  - A partial record is discarded.
- Width rules: metrics are 8-bit unsigned with no saturation. Normalization keeps the spread small enough that overflow cannot occur (growth ≤2 per symbol).

Test Plan:
- Reset asserted in RUN at idx=4 → next cycle IDLE, sym_ready=1, surv_valid=0, all outputs 0; the next symbol with sym_start=0 sees only state 0 valid.
- After reset, symbol 00 → cycle 9: surv_valid=1, surv_mask=8'h11, surv_bits=8'h00, best_state=0, best_metric=0. Next-bank metrics: state0=0, state4=2.
- Hold surv_ready=0 for 5 cycles in OUT → outputs stable, sym_ready=0, a pending sym_valid is not accepted; surv_ready=1 → IDLE next cycle.
- Encode 16 bits of an all-zero message, each symbol 00 → every record has best_state=0, best_metric=0, and from symbol 3 on surv_mask=8'hFF.
- Encode random bits, inject 1 bit error; compare against a reference model → surv_bits and best_metric match per symbol.
- Preload the metrics with all valid values ≥128 (long noisy stream) → after the swap all metrics drop by 128 and ordering is preserved; a mid-stream sym_start restores the initial metrics.
